// File: rtl/common_pkg.sv
// Shared ALU op codes and arbiter port typing used by the alu and its arbiter.
package common;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam int ALU_PORTS = 2;

    typedef logic [0:0] alu_port_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unrecognised op codes fall back to addition.
module alu
    import common::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] Left,
    input  logic [DATA_WIDTH-1:0] Right,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  ZeroFlag
);

    logic [4:0] w_shamt;

    assign w_shamt = Right[4:0];

    always_comb begin
        Result = Left + Right;
        case (ALUControl)
            ALU_SUB:  Result = Left - Right;
            ALU_AND:  Result = Left & Right;
            ALU_OR:   Result = Left | Right;
            ALU_XOR:  Result = Left ^ Right;
            ALU_SLL:  Result = Left << w_shamt;
            ALU_SRL:  Result = Left >> w_shamt;
            ALU_SRA:  Result = $unsigned($signed(Left) >>> w_shamt);
            ALU_SLT: begin
                Result    = '0;
                Result[0] = $signed(Left) < $signed(Right);
            end
            ALU_SLTU: begin
                Result    = '0;
                Result[0] = Left < Right;
            end
            default:  Result = Left + Right;
        endcase
    end

    assign ZeroFlag = (Result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (port 0) and the
// branch/address unit (port 1), each with a one-entry response buffer.
module alu_arbiter
    import common::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ALU_PORTS-1:0]                 req_valid,
    output logic [ALU_PORTS-1:0]                 req_ready,
    input  logic [ALU_PORTS-1:0][3:0]            req_control,
    input  logic [ALU_PORTS-1:0][DATA_WIDTH-1:0] req_left,
    input  logic [ALU_PORTS-1:0][DATA_WIDTH-1:0] req_right,
    output logic [ALU_PORTS-1:0]                 rsp_valid,
    input  logic [ALU_PORTS-1:0]                 rsp_ready,
    output logic [ALU_PORTS-1:0][DATA_WIDTH-1:0] rsp_result,
    output logic [ALU_PORTS-1:0]                 rsp_zero,
    output logic [ALU_PORTS-1:0][CNT_WIDTH-1:0]  grant_cnt
);

    alu_port_t                                r_prio;
    logic [ALU_PORTS-1:0]                     r_rspValid;
    logic [ALU_PORTS-1:0][DATA_WIDTH-1:0]     r_rspResult;
    logic [ALU_PORTS-1:0]                     r_rspZero;
    logic [ALU_PORTS-1:0][CNT_WIDTH-1:0]      r_grantCnt;

    logic [ALU_PORTS-1:0]  w_elig;
    logic [ALU_PORTS-1:0]  w_cand;
    logic                  w_grantValid;
    alu_port_t             w_grantIdx;
    logic [3:0]            w_aluControl;
    logic [DATA_WIDTH-1:0] w_aluLeft;
    logic [DATA_WIDTH-1:0] w_aluRight;
    logic [DATA_WIDTH-1:0] w_aluResult;

    // A slot being drained this cycle is already free for a new grant.
    always_comb begin
        w_elig       = ~r_rspValid | rsp_ready;
        w_cand       = req_valid & w_elig;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        req_ready    = '0;
        if (!reset) begin
            if (w_cand[0] && w_cand[1]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = r_prio;
            end else if (w_cand[1]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = 1'b1;
            end else if (w_cand[0]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = 1'b0;
            end
        end
        if (w_grantValid) begin
            req_ready[w_grantIdx] = 1'b1;
        end
        w_aluControl = req_control[w_grantIdx];
        w_aluLeft    = req_left[w_grantIdx];
        w_aluRight   = req_right[w_grantIdx];
    end

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .ALUControl(w_aluControl),
        .Left      (w_aluLeft),
        .Right     (w_aluRight),
        .Result    (w_aluResult),
        .ZeroFlag  ()
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio      <= '0;
            r_rspValid  <= '0;
            r_rspResult <= '0;
            r_rspZero   <= '0;
            r_grantCnt  <= '0;
        end else begin
            if (w_grantValid) begin
                r_prio <= ~w_grantIdx;
            end
            for (int i = 0; i < ALU_PORTS; i++) begin
                if (w_grantValid && (w_grantIdx == alu_port_t'(i))) begin
                    r_rspValid[i]  <= 1'b1;
                    r_rspResult[i] <= w_aluResult;
                    r_rspZero[i]   <= (w_aluResult == '0);
                    if (r_grantCnt[i] != '1) begin
                        r_grantCnt[i] <= r_grantCnt[i] + 1'b1;
                    end
                end else if (rsp_ready[i]) begin
                    r_rspValid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid  = r_rspValid;
    assign rsp_result = r_rspResult;
    assign rsp_zero   = r_rspZero;
    assign grant_cnt  = r_grantCnt;

endmodule
